// File: rtl/mmio_periph_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_periph_responder_pkg
// Description : Register offsets and TCON layout shared by the peripheral
//               responder, the CPU read-mux decode and software headers.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_periph_responder_pkg;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  typedef struct packed {
    logic irq;
    logic ie;
    logic en;
  } tcon_t;

endpackage
`default_nettype wire

// File: rtl/mmio_periph_responder_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seg_scanner
// Description : 4-digit multiplexed hex display driver, active-low outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_digits,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_ano
);

  localparam int              CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    w_nib;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == TC) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_nib = i_digits[{r_idx, 2'b00} +: 4];
  assign o_ano = ~(4'b0001 << r_idx);

  // Bit order g..a, low means segment lit.
  always_comb begin
    o_seg = 7'b1111111;
    case (w_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mmio_periph_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_periph_responder
// Description : Memory-mapped timer, LED, hex display and systick block.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_periph_responder
  import mmio_periph_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [6:0]  Seg,
  output logic [3:0]  Ano
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  tcon_t       r_tcon;
  logic [7:0]  r_led;
  logic [15:0] r_digits;
  logic [31:0] r_tick;

  logic [4:0]  w_off;
  logic        w_wr;
  logic        w_ovf;
  logic        w_hw_irq;

  // Byte lanes are ignored, so the offset is word-aligned.
  assign w_off    = Address[4:0] & 5'b11100;
  assign Hit      = (Address[31:5] == BASE_ADDR[31:5]) && (w_off <= OFF_SYSTICK);
  assign w_wr     = MemWrite && Hit;
  assign w_ovf    = r_tcon.en && (r_tl == 32'hFFFF_FFFF);
  assign w_hw_irq = w_ovf && r_tcon.ie;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th     <= '0;
      r_tl     <= '0;
      r_tcon   <= '0;
      r_led    <= '0;
      r_digits <= '0;
      r_tick   <= '0;
    end else begin
      r_tick <= r_tick + 32'd1;

      if (w_wr && w_off == OFF_TH)     r_th     <= Write_data;
      if (w_wr && w_off == OFF_LED)    r_led    <= Write_data[7:0];
      if (w_wr && w_off == OFF_DIGITS) r_digits <= Write_data[15:0];

      if (w_wr && w_off == OFF_TL)
        r_tl <= Write_data;
      else if (r_tcon.en)
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;

      // A hardware overflow set wins over a software clear in the same cycle.
      if (w_wr && w_off == OFF_TCON) begin
        r_tcon.en  <= Write_data[TCON_EN];
        r_tcon.ie  <= Write_data[TCON_IE];
        r_tcon.irq <= Write_data[TCON_IRQ] | w_hw_irq;
      end else if (w_hw_irq) begin
        r_tcon.irq <= 1'b1;
      end
    end
  end

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && Hit) begin
      case (w_off)
        OFF_TH:      Read_data = r_th;
        OFF_TL:      Read_data = r_tl;
        OFF_TCON:    Read_data = {29'd0, r_tcon};
        OFF_LED:     Read_data = {24'd0, r_led};
        OFF_DIGITS:  Read_data = {16'd0, r_digits};
        OFF_SYSTICK: Read_data = r_tick;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  assign irq = r_tcon.irq;
  assign led = r_led;

  seg_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scanner (
    .clk      (clk),
    .reset    (reset),
    .i_digits (r_digits),
    .o_seg    (Seg),
    .o_ano    (Ano)
  );

endmodule
`default_nettype wire
